// File: rtl/tpu_isa_pkg.sv
// Shared TPU instruction-set definitions: opcodes, field positions, the packed
// instruction layout and the issuer FSM state type.
package tpu_isa_pkg;

   localparam logic [7:0]  OP_WMMA_FP16      = 8'h03;
   localparam logic [7:0]  OP_INT8_DP        = 8'h04;
   localparam logic [7:0]  OP_DMA            = 8'h10;
   localparam logic [7:0]  OP_SCATTER_GATHER = 8'h11;
   localparam logic [7:0]  OP_CONV2D         = 8'h20;
   localparam logic [7:0]  OP_ATTENTION      = 8'h21;
   localparam logic [7:0]  OP_FUSED_MMA_RELU = 8'h30;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 24;
   localparam int REGA_MSB = 23;
   localparam int REGA_LSB = 16;
   localparam int REGB_MSB = 15;
   localparam int REGB_LSB = 12;
   localparam int REGC_MSB = 11;
   localparam int REGC_LSB = 8;
   localparam int IMM_MSB  = 7;
   localparam int IMM_LSB  = 0;

   // Response word is {opcode, result}
   localparam int RSP_W = 40;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] reg_a;
      logic [3:0] reg_b;
      logic [3:0] reg_c;
      logic [7:0] imm;
   } tpu_instr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } issuer_state_t;

endpackage

// File: rtl/tpu_sync_fifo.sv
// Single-clock FIFO, no fall-through. A push into a full FIFO is accepted when
// a pop happens in the same cycle.
module tpu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_pop;
   logic w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tpu_instr_issuer.sv
// Host-side TPU instruction issuer: buffers command words, holds each on
// instruction_out for HOLD_CYCLES, samples result_in and queues {opcode, result}.
//
// state    | meaning
// ST_IDLE  | nothing issuing, instruction_out = NOP, waiting for a command
// ST_ISSUE | instruction held on the TPU, hold counter running down
// ST_STALL | result due but response FIFO full; re-sample until space appears
module tpu_instr_issuer
   import tpu_isa_pkg::*;
#(
   parameter int CMD_DEPTH   = 8,
   parameter int RSP_DEPTH   = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_data,
   output logic [31:0] instruction_out,
   input  logic [31:0] result_in,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_opcode,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic [15:0] issued_count
);
   localparam int          HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

   issuer_state_t   r_state;
   tpu_instr_t      r_instr;
   logic [HW-1:0]   r_hold;
   logic [15:0]     r_issued;

   logic             w_cmd_full;
   logic             w_cmd_empty;
   logic             w_cmd_push;
   logic             w_cmd_pop;
   logic [31:0]      w_cmd_head;
   logic             w_rsp_full;
   logic             w_rsp_empty;
   logic             w_rsp_push;
   logic             w_rsp_pop;
   logic             w_rsp_space;
   logic             w_sample;
   logic [RSP_W-1:0] w_rsp_wdata;
   logic [RSP_W-1:0] w_rsp_head;

   // The result is due on the last hold cycle, or every cycle while stalled
   assign w_sample    = ((r_state == ST_ISSUE) && (r_hold == '0)) || (r_state == ST_STALL);
   assign w_rsp_pop   = !w_rsp_empty && rsp_ready;
   assign w_rsp_space = !w_rsp_full || w_rsp_pop;
   assign w_rsp_push  = w_sample && w_rsp_space;
   assign w_cmd_pop   = !w_cmd_empty && ((r_state == ST_IDLE) || w_rsp_push);
   assign w_cmd_push  = cmd_valid && cmd_ready;
   assign w_rsp_wdata = {instruction_out[OPC_MSB:OPC_LSB], result_in};

   // A full command FIFO still takes a word when the FSM pops in the same cycle
   assign cmd_ready       = !w_cmd_full || w_cmd_pop;
   assign rsp_valid       = !w_rsp_empty;
   assign rsp_opcode      = w_rsp_head[RSP_W-1:32];
   assign rsp_data        = w_rsp_head[31:0];
   assign busy            = (r_state != ST_IDLE) || !w_cmd_empty;
   assign instruction_out = r_instr;
   assign issued_count    = r_issued;

   tpu_sync_fifo #(
      .WIDTH (32),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_cmd_push),
      .i_data  (cmd_data),
      .i_pop   (w_cmd_pop),
      .o_data  (w_cmd_head),
      .o_full  (w_cmd_full),
      .o_empty (w_cmd_empty)
   );

   tpu_sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rsp_push),
      .i_data  (w_rsp_wdata),
      .i_pop   (w_rsp_pop),
      .o_data  (w_rsp_head),
      .o_full  (w_rsp_full),
      .o_empty (w_rsp_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_instr  <= INSTR_NOP;
         r_hold   <= '0;
         r_issued <= '0;
      end else begin
         if (w_rsp_push) begin
            r_issued <= r_issued + 16'd1;
         end
         case (r_state)
            ST_IDLE: begin
               r_instr <= INSTR_NOP;
               if (!w_cmd_empty) begin
                  r_instr <= w_cmd_head;
                  r_hold  <= HOLD_RELOAD;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_STALL: begin
               if ((r_state == ST_ISSUE) && (r_hold != '0)) begin
                  r_hold <= r_hold - HOLD_ONE;
               end else if (w_rsp_push) begin
                  // Chain straight into the next word so there is no NOP gap
                  if (!w_cmd_empty) begin
                     r_instr <= w_cmd_head;
                     r_hold  <= HOLD_RELOAD;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_instr <= INSTR_NOP;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_STALL;
               end
            end
            default: begin
               r_instr <= INSTR_NOP;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
